// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//   General-purpose register file for the vector-encryption CPU datapath.
//   Holds NREGS = 2**ADDR_WIDTH registers of DATA_WIDTH bits.
//   It has two combinational read ports and one synchronous write port.
//   Register 0 is hardwired to zero.
//
// Ports
//   clk       in   1           single clock, rising-edge
//   rst       in   1           synchronous, active-low reset (clears all regs)
//   regWrite  in   1           write enable, sampled at rising clk
//   A1, A2    in   ADDR_WIDTH  read addresses
//   A3        in   ADDR_WIDTH  write address
//   WD3       in   DATA_WIDTH  write data
//   RD1, RD2  out  DATA_WIDTH  read data (zero-cycle latency)
//
// Configuration
//   REGFILE_BYPASS_EN : when defined, a write in flight to the address being
//   read is forwarded combinationally onto the read port. When undefined,
//   reads return the stored contents only.
// ---------------------------------------------------------------------------
module register_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  input  logic [ADDR_WIDTH-1:0] A3,
  input  logic [DATA_WIDTH-1:0] WD3,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2
);

  localparam int NREGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREGS];
  logic                  writeValid;

  // A write only takes effect outside reset and never targets register 0.
  assign writeValid = regWrite && rst && (A3 != '0);

  // Storage update. Reset wins over any write in the same cycle. Register 0
  // is cleared by reset and is never written, so it always holds zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (writeValid) begin
      regs[A3] <= WD3;
    end
  end

  // Read port 1. Address 0 is forced to zero, not just left to stored contents,
  // so RD1 is zero from time 0 even before the first reset edge.
  always_comb begin
    RD1 = '0;
    if (A1 != '0) begin
`ifdef REGFILE_BYPASS_EN
      if (writeValid && (A1 == A3)) begin
        RD1 = WD3;
      end else begin
        RD1 = regs[A1];
      end
`else
      RD1 = regs[A1];
`endif
    end
  end

  // Read port 2 mirrors port 1.
  always_comb begin
    RD2 = '0;
    if (A2 != '0) begin
`ifdef REGFILE_BYPASS_EN
      if (writeValid && (A2 == A3)) begin
        RD2 = WD3;
      end else begin
        RD2 = regs[A2];
      end
`else
      RD2 = regs[A2];
`endif
    end
  end

endmodule

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
//   Directed self-checking bench for register_file. It uses hand-computed
//   expected values.
//   Inputs change 1ns after each rising edge. Outputs are checked once the
//   combinational read paths have settled, well before the next edge.
// ---------------------------------------------------------------------------
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        regWrite;
  logic [3:0]  A1;
  logic [3:0]  A2;
  logic [3:0]  A3;
  logic [15:0] WD3;
  logic [15:0] RD1;
  logic [15:0] RD2;

  int checkCount;
  int failCount;

  register_file #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .regWrite (regWrite),
    .A1       (A1),
    .A2       (A2),
    .A3       (A3),
    .WD3      (WD3),
    .RD1      (RD1),
    .RD2      (RD2)
  );

  // 10ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive reset and write controls, then advance one rising edge.
  task automatic applyStimulus(input logic rstV, input logic weV,
                               input logic [3:0] a3V, input logic [15:0] wdV);
    rst      = rstV;
    regWrite = weV;
    A3       = a3V;
    WD3      = wdV;
    @(posedge clk);
    #1;
    rst      = 1'b1;
    regWrite = 1'b0;
  endtask

  // Set the read addresses and let the read paths settle.
  task automatic setRead(input logic [3:0] a1V, input logic [3:0] a2V);
    A1 = a1V;
    A2 = a2V;
    #1;
  endtask

  logic [15:0] pattern;

  initial begin
    checkCount = 0;
    failCount  = 0;
    rst = 1'b1; regWrite = 1'b0;
    A1 = '0; A2 = '0; A3 = '0; WD3 = '0;
    #2;

    // Reset, then sweep all addresses on both ports.
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      setRead(4'(i), 4'(15 - i));
      checkOutput($sformatf("reset_rd1_a%0d", i), RD1, 16'h0000);
      checkOutput($sformatf("reset_rd2_a%0d", 15 - i), RD2, 16'h0000);
    end

    // Write then read.
    applyStimulus(1'b1, 1'b1, 4'd1, 16'h1234);
    setRead(4'd1, 4'd0);
    checkOutput("wr1_rd1", RD1, 16'h1234);
    checkOutput("wr1_rd2_r0", RD2, 16'h0000);

    // Second register; reg1 retained.
    applyStimulus(1'b1, 1'b1, 4'd2, 16'hABCD);
    setRead(4'd2, 4'd1);
    checkOutput("wr2_rd1", RD1, 16'hABCD);
    checkOutput("wr2_rd2_reg1", RD2, 16'h1234);
    setRead(4'd2, 4'd2);
    checkOutput("same_addr_rd1", RD1, 16'hABCD);
    checkOutput("same_addr_rd2", RD2, 16'hABCD);

    // Register 0 ignores writes; a disabled write changes nothing.
    applyStimulus(1'b1, 1'b1, 4'd0, 16'hFFFF);
    setRead(4'd0, 4'd0);
    checkOutput("r0_rd1", RD1, 16'h0000);
    checkOutput("r0_rd2", RD2, 16'h0000);
    applyStimulus(1'b1, 1'b0, 4'd3, 16'h5555);
    setRead(4'd3, 4'd1);
    checkOutput("we0_reg3", RD1, 16'h0000);
    checkOutput("we0_reg1_kept", RD2, 16'h1234);

    // Synchronous reset mid-operation overrides a concurrent write.
    applyStimulus(1'b0, 1'b1, 4'd4, 16'h9999);
    setRead(4'd1, 4'd2);
    checkOutput("midrst_reg1", RD1, 16'h0000);
    checkOutput("midrst_reg2", RD2, 16'h0000);
    setRead(4'd4, 4'd4);
    checkOutput("midrst_reg4", RD1, 16'h0000);

    // Same-cycle read/write.
    applyStimulus(1'b1, 1'b1, 4'd5, 16'h1111);
    A1 = 4'd5; A2 = 4'd6; A3 = 4'd5; WD3 = 16'h2222; regWrite = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("rdw_before_edge", RD1, 16'h2222);
`else
    checkOutput("rdw_before_edge", RD1, 16'h1111);
`endif
    checkOutput("rdw_other_port", RD2, 16'h0000);
    @(posedge clk);
    #1;
    regWrite = 1'b0;
    #1;
    checkOutput("rdw_after_edge", RD1, 16'h2222);

    // A pending write to register 0 never shows on a read of address 0.
    A1 = 4'd0; A3 = 4'd0; WD3 = 16'hDEAD; regWrite = 1'b1;
    #1;
    checkOutput("r0_no_forward", RD1, 16'h0000);
    @(posedge clk);
    #1;
    regWrite = 1'b0;

    // Fill every register with a distinct value, then read it all back.
    for (int i = 1; i < 16; i++) begin
      pattern = 16'(i * 16'h0101) ^ 16'hA050;
      applyStimulus(1'b1, 1'b1, 4'(i), pattern);
    end
    for (int i = 0; i < 16; i++) begin
      setRead(4'(i), 4'(15 - i));
      pattern = (i == 0) ? 16'h0000 : (16'(i * 16'h0101) ^ 16'hA050);
      checkOutput($sformatf("fill_rd1_a%0d", i), RD1, pattern);
      pattern = (i == 15) ? 16'h0000 : (16'((15 - i) * 16'h0101) ^ 16'hA050);
      checkOutput($sformatf("fill_rd2_a%0d", 15 - i), RD2, pattern);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
